// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the programmable clock divider.
package clk_div_pkg;

    // Default divisor / counter width.
    localparam int unsigned DIV_W_DEF     = 8;
    // Smallest divisor that still produces a toggling output.
    localparam int unsigned MIN_DIV       = 2;
    // Divisor that is active straight out of reset.
    localparam int unsigned RESET_DIV_DEF = 3;

    // Outcome of a div_load strobe in the current cycle.
    typedef enum logic [1:0] {
        LdNone,    // no strobe
        LdReject,  // divisor below MIN_DIV, flag error and keep everything
        LdDefer,   // park in shadow register until the next wrap
        LdApply    // take effect at this edge (idle, or strobe lands on a wrap)
    } load_act_e;

    // Number of clk_in cycles the posedge-registered output term stays high.
    // With the half-cycle stage present, odd divisors drop one half cycle here
    // and the negedge copy adds it back.
    function automatic int unsigned hi_cycles(input int unsigned d, input logic odd50);
        if (odd50 && d[0]) begin
            return d >> 1;
        end
        return (d + 1) >> 1;
    endfunction

endpackage

// File: rtl/clk_div_odd_stage.sv
// Half-cycle extension stage: delays the posedge output term by a negedge
// flop and ORs it back in, stretching odd-divisor high time to exactly D/2.
module clk_div_odd_stage (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic pos_i,   // posedge-registered output term
    input  logic odd_i,   // active divisor is odd for the current phase
    output logic clk_o
);

    logic neg_q;

    // Capture the posedge term on the falling edge; even divisors never extend.
    always_ff @(negedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            neg_q <= 1'b0;
        end else begin
            neg_q <= pos_i & odd_i;
        end
    end

    assign clk_o = pos_i | neg_q;

endmodule

// File: rtl/clock_divider_n.sv
// Programmable integer clock divider with glitch-free divisor reload.
// The divided clock, tick and status flags are all registered on clk_in.
// Optional build macro CLK_DIV_ODD_50_EN adds a negedge stage that gives odd
// divisors an exact 50% duty cycle; without it odd divisors run (D+1)/2 high.
// reset_n is expected to be deasserted synchronously to clk_in upstream.
module clock_divider_n
    import clk_div_pkg::*;
#(
    parameter int unsigned DIV_W     = DIV_W_DEF,
    parameter int unsigned RESET_DIV = RESET_DIV_DEF
) (
    input  logic             clk_in,
    input  logic             reset_n,
    input  logic             en,
    input  logic [DIV_W-1:0] div_in,
    input  logic             div_load,
    output logic             clk_out,
    output logic             tick,
    output logic             div_pending,
    output logic             div_err
);

    localparam logic [DIV_W-1:0] ResetDiv = DIV_W'(RESET_DIV);
    localparam logic [DIV_W-1:0] MinDiv   = DIV_W'(MIN_DIV);
`ifdef CLK_DIV_ODD_50_EN
    localparam logic Odd50 = 1'b1;
`else
    localparam logic Odd50 = 1'b0;
`endif

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] shadow_q, shadow_d;
    logic             pend_q, pend_d;
    logic             err_q, err_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;

    logic [DIV_W-1:0] last_cnt;
    logic             wrap;
    int unsigned      hi_cnt;
    load_act_e        load_act;

    assign last_cnt = div_q - DIV_W'(1);
    // >= rather than == keeps the counter bounded even if div_q ever shrank below it.
    assign wrap     = en && (cnt_q >= last_cnt);

    // Classify this cycle's load strobe.
    always_comb begin
        load_act = LdNone;
        if (div_load) begin
            if (div_in < MinDiv) begin
                load_act = LdReject;
            end else if (!en || wrap) begin
                load_act = LdApply;
            end else begin
                load_act = LdDefer;
            end
        end
    end

    // Next-state for the counter and the divisor/shadow/status registers.
    always_comb begin
        cnt_d    = cnt_q;
        div_d    = div_q;
        shadow_d = shadow_q;
        pend_d   = pend_q;
        err_d    = err_q;

        // A parked divisor goes live at the period boundary, or at once when
        // idle since the counter is parked at 0 and nothing can be disturbed.
        if (pend_q && (wrap || !en)) begin
            div_d  = shadow_q;
            pend_d = 1'b0;
        end

        unique case (load_act)
            LdReject: begin
                err_d = 1'b1;
            end
            LdApply: begin
                div_d    = div_in;
                shadow_d = div_in;
                pend_d   = 1'b0;
                err_d    = 1'b0;
            end
            LdDefer: begin
                shadow_d = div_in;
                pend_d   = 1'b1;
                err_d    = 1'b0;
            end
            default: ;
        endcase

        if (!en || wrap) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + DIV_W'(1);
        end
    end

    // Output terms for the phase held in cnt_q, registered on the next edge.
    always_comb begin
        hi_cnt = hi_cycles(32'(div_q), Odd50);
        clk_d  = en && (32'(cnt_q) < hi_cnt);
        tick_d = en && (cnt_q == '0);
    end

    // Main state register; reset aborts the current period outright.
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q    <= '0;
            div_q    <= ResetDiv;
            shadow_q <= ResetDiv;
            pend_q   <= 1'b0;
            err_q    <= 1'b0;
            clk_q    <= 1'b0;
            tick_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            div_q    <= div_d;
            shadow_q <= shadow_d;
            pend_q   <= pend_d;
            err_q    <= err_d;
            clk_q    <= clk_d;
            tick_q   <= tick_d;
        end
    end

`ifdef CLK_DIV_ODD_50_EN
    logic odd_q;

    // Remember whether the phase just registered belongs to an odd divisor.
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            odd_q <= 1'b0;
        end else begin
            odd_q <= en && div_q[0];
        end
    end

    clk_div_odd_stage u_odd_stage (
        .clk_i  (clk_in),
        .rst_ni (reset_n),
        .pos_i  (clk_q),
        .odd_i  (odd_q),
        .clk_o  (clk_out)
    );
`else
    assign clk_out = clk_q;
`endif

    assign tick        = tick_q;
    assign div_pending = pend_q;
    assign div_err     = err_q;

endmodule
